// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Purpose  : Five-stage pipeline control: per-stage stall/clear, operand
//             forwarding selects and a saturating redirect counter.
//             Build macro FWD_EN enables EX/ME forwarding (otherwise every RAW
//             hazard on an in-flight producer interlocks).
//  Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int N_STAGES    = 5,
    parameter int REG_IDX_W   = 5,
    parameter int MULTI_LAT   = 4,
    parameter int INIT_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 i_fe_busy,
    input  logic                 i_me_busy,
    input  logic [REG_IDX_W-1:0] i_id_rs1,
    input  logic [REG_IDX_W-1:0] i_id_rs2,
    input  logic                 i_id_rs1_en,
    input  logic                 i_id_rs2_en,
    input  logic                 i_ex_dest_en,
    input  logic [REG_IDX_W-1:0] i_ex_dest_reg,
    input  logic                 i_ex_is_load,
    input  logic                 i_me_dest_en,
    input  logic [REG_IDX_W-1:0] i_me_dest_reg,
    input  logic                 i_ex_redirect,
    input  logic                 i_ex_multi_start,
    output logic [N_STAGES-1:0]  o_stall,
    output logic [N_STAGES-1:0]  o_clr,
    output logic [1:0]           o_fwd_a_sel,
    output logic [1:0]           o_fwd_b_sel,
    output logic [CNT_W-1:0]     o_flush_cnt
);

    localparam int c_init_w  = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int c_multi_w = (MULTI_LAT > 1) ? $clog2(MULTI_LAT) : 1;
    localparam bit c_multi_en = (MULTI_LAT > 1);

    localparam logic [c_init_w-1:0]  c_init_load  = c_init_w'(INIT_CYCLES - 1);
    localparam logic [c_init_w-1:0]  c_init_one   = c_init_w'(1);
    localparam logic [c_multi_w-1:0] c_multi_load = c_multi_w'(MULTI_LAT - 1);
    localparam logic [c_multi_w-1:0] c_multi_one  = c_multi_w'(1);
    localparam logic [CNT_W-1:0]     c_cnt_one    = CNT_W'(1);

    localparam logic [N_STAGES-1:0] c_all_ones    = 5'b11111;
    localparam logic [N_STAGES-1:0] c_none        = 5'b00000;
    localparam logic [N_STAGES-1:0] c_stall_me    = 5'b01111;
    localparam logic [N_STAGES-1:0] c_clr_me      = 5'b10000;
    localparam logic [N_STAGES-1:0] c_stall_multi = 5'b00111;
    localparam logic [N_STAGES-1:0] c_clr_multi   = 5'b01000;
    localparam logic [N_STAGES-1:0] c_clr_redir   = 5'b00110;
    localparam logic [N_STAGES-1:0] c_stall_intlk = 5'b00011;
    localparam logic [N_STAGES-1:0] c_clr_intlk   = 5'b00100;
    localparam logic [N_STAGES-1:0] c_stall_fe    = 5'b00001;
    localparam logic [N_STAGES-1:0] c_clr_fe      = 5'b00010;

    localparam logic [1:0] c_fwd_rf = 2'b00;
    localparam logic [1:0] c_fwd_ex = 2'b01;
    localparam logic [1:0] c_fwd_me = 2'b10;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_MULTI = 2'd2
    } state_t;

    state_t                 r_state_q,     w_state_d;
    logic [c_init_w-1:0]    r_init_cnt_q,  w_init_cnt_d;
    logic [c_multi_w-1:0]   r_multi_cnt_q, w_multi_cnt_d;
    logic [CNT_W-1:0]       r_flush_cnt_q, w_flush_cnt_d;

    // Source/destination matches; x0 is excluded by requiring a nonzero source.
    logic w_rs1_ex, w_rs2_ex, w_rs1_me, w_rs2_me;
    logic w_interlock;
    logic [1:0] w_fwd_a, w_fwd_b;

    assign w_rs1_ex = i_id_rs1_en && (i_id_rs1 != '0) && i_ex_dest_en && (i_id_rs1 == i_ex_dest_reg);
    assign w_rs2_ex = i_id_rs2_en && (i_id_rs2 != '0) && i_ex_dest_en && (i_id_rs2 == i_ex_dest_reg);
    assign w_rs1_me = i_id_rs1_en && (i_id_rs1 != '0) && i_me_dest_en && (i_id_rs1 == i_me_dest_reg);
    assign w_rs2_me = i_id_rs2_en && (i_id_rs2 != '0) && i_me_dest_en && (i_id_rs2 == i_me_dest_reg);

`ifdef FWD_EN
    // A load result is not available until ME, so only load-use must wait.
    assign w_interlock = i_ex_is_load && (w_rs1_ex || w_rs2_ex);
    assign w_fwd_a = (w_rs1_ex && !i_ex_is_load) ? c_fwd_ex :
                     w_rs1_me                    ? c_fwd_me : c_fwd_rf;
    assign w_fwd_b = (w_rs2_ex && !i_ex_is_load) ? c_fwd_ex :
                     w_rs2_me                    ? c_fwd_me : c_fwd_rf;
`else
    logic w_unused_is_load;
    assign w_unused_is_load = i_ex_is_load;
    assign w_interlock = w_rs1_ex || w_rs2_ex || w_rs1_me || w_rs2_me;
    assign w_fwd_a     = c_fwd_rf;
    assign w_fwd_b     = c_fwd_rf;
`endif

    always_comb begin
        w_state_d     = r_state_q;
        w_init_cnt_d  = r_init_cnt_q;
        w_multi_cnt_d = r_multi_cnt_q;
        w_flush_cnt_d = r_flush_cnt_q;
        o_stall       = c_none;
        o_clr         = c_none;
        o_fwd_a_sel   = c_fwd_rf;
        o_fwd_b_sel   = c_fwd_rf;

        case (r_state_q)
            ST_RUN, ST_MULTI: begin
                o_fwd_a_sel = w_fwd_a;
                o_fwd_b_sel = w_fwd_b;
                if (i_me_busy) begin
                    o_stall = c_stall_me;
                    o_clr   = c_clr_me;
                end else if (r_state_q == ST_MULTI) begin
                    o_stall = c_stall_multi;
                    o_clr   = c_clr_multi;
                    w_multi_cnt_d = r_multi_cnt_q - c_multi_one;
                    if (r_multi_cnt_q == c_multi_one) begin
                        w_state_d = ST_RUN;
                    end
                end else if (i_ex_multi_start && c_multi_en) begin
                    // The start cycle itself is the first of MULTI_LAT held cycles.
                    o_stall       = c_stall_multi;
                    o_clr         = c_clr_multi;
                    w_multi_cnt_d = c_multi_load;
                    w_state_d     = ST_MULTI;
                end else if (i_ex_redirect) begin
                    o_clr = c_clr_redir;
                    if (r_flush_cnt_q != {CNT_W{1'b1}}) begin
                        w_flush_cnt_d = r_flush_cnt_q + c_cnt_one;
                    end
                end else if (w_interlock) begin
                    o_stall = c_stall_intlk;
                    o_clr   = c_clr_intlk;
                end else if (i_fe_busy) begin
                    o_stall = c_stall_fe;
                    o_clr   = c_clr_fe;
                end
            end
            default: begin
                o_clr = c_all_ones;
                if (r_state_q != ST_INIT || r_init_cnt_q == '0) begin
                    w_state_d = ST_RUN;
                end else begin
                    w_init_cnt_d = r_init_cnt_q - c_init_one;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q     <= ST_INIT;
            r_init_cnt_q  <= c_init_load;
            r_multi_cnt_q <= '0;
            r_flush_cnt_q <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_init_cnt_q  <= w_init_cnt_d;
            r_multi_cnt_q <= w_multi_cnt_d;
            r_flush_cnt_q <= w_flush_cnt_d;
        end
    end

    assign o_flush_cnt = r_flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Purpose  : Directed scoreboard bench for pipe_hazard_ctrl (honours FWD_EN).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

`ifdef FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       aresetn;
    logic       i_fe_busy, i_me_busy;
    logic [4:0] i_id_rs1, i_id_rs2;
    logic       i_id_rs1_en, i_id_rs2_en;
    logic       i_ex_dest_en, i_ex_is_load;
    logic [4:0] i_ex_dest_reg;
    logic       i_me_dest_en;
    logic [4:0] i_me_dest_reg;
    logic       i_ex_redirect, i_ex_multi_start;

    logic [4:0]  o_stall, o_clr;
    logic [1:0]  o_fwd_a_sel, o_fwd_b_sel;
    logic [15:0] o_flush_cnt;

    logic [4:0]  s2_stall, s2_clr;
    logic [1:0]  s2_fa, s2_fb;
    logic [1:0]  s2_flush_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.N_STAGES(5), .REG_IDX_W(5), .MULTI_LAT(4), .INIT_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .aresetn(aresetn),
        .i_fe_busy(i_fe_busy), .i_me_busy(i_me_busy),
        .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
        .i_id_rs1_en(i_id_rs1_en), .i_id_rs2_en(i_id_rs2_en),
        .i_ex_dest_en(i_ex_dest_en), .i_ex_dest_reg(i_ex_dest_reg), .i_ex_is_load(i_ex_is_load),
        .i_me_dest_en(i_me_dest_en), .i_me_dest_reg(i_me_dest_reg),
        .i_ex_redirect(i_ex_redirect), .i_ex_multi_start(i_ex_multi_start),
        .o_stall(o_stall), .o_clr(o_clr),
        .o_fwd_a_sel(o_fwd_a_sel), .o_fwd_b_sel(o_fwd_b_sel),
        .o_flush_cnt(o_flush_cnt)
    );

    pipe_hazard_ctrl #(.N_STAGES(5), .REG_IDX_W(5), .MULTI_LAT(4), .INIT_CYCLES(2), .CNT_W(2)) dut_sat (
        .clk(clk), .aresetn(aresetn),
        .i_fe_busy(i_fe_busy), .i_me_busy(i_me_busy),
        .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
        .i_id_rs1_en(i_id_rs1_en), .i_id_rs2_en(i_id_rs2_en),
        .i_ex_dest_en(i_ex_dest_en), .i_ex_dest_reg(i_ex_dest_reg), .i_ex_is_load(i_ex_is_load),
        .i_me_dest_en(i_me_dest_en), .i_me_dest_reg(i_me_dest_reg),
        .i_ex_redirect(i_ex_redirect), .i_ex_multi_start(i_ex_multi_start),
        .o_stall(s2_stall), .o_clr(s2_clr),
        .o_fwd_a_sel(s2_fa), .o_fwd_b_sel(s2_fb),
        .o_flush_cnt(s2_flush_cnt)
    );

    typedef struct {
        string      nm;
        logic [4:0] st;
        logic [4:0] cl;
        logic [1:0] fa;
        logic [1:0] fb;
        int         fl;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_errors = 0;

    // Monitor: one expected response per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (o_stall !== e.st || o_clr !== e.cl || o_fwd_a_sel !== e.fa ||
                o_fwd_b_sel !== e.fb || int'(o_flush_cnt) != e.fl ||
                int'(s2_flush_cnt) != ((e.fl > 3) ? 3 : e.fl) || s2_stall !== e.st ||
                s2_clr !== e.cl) begin
                n_errors++;
                $display("FAIL %s: got stall=%b clr=%b fa=%b fb=%b cnt=%0d cnt2=%0d, expected stall=%b clr=%b fa=%b fb=%b cnt=%0d cnt2=%0d",
                         e.nm, o_stall, o_clr, o_fwd_a_sel, o_fwd_b_sel, o_flush_cnt, s2_flush_cnt,
                         e.st, e.cl, e.fa, e.fb, e.fl, (e.fl > 3) ? 3 : e.fl);
            end
        end
    end

    task automatic idle_inputs();
        i_fe_busy = 0; i_me_busy = 0;
        i_id_rs1 = 0; i_id_rs2 = 0; i_id_rs1_en = 0; i_id_rs2_en = 0;
        i_ex_dest_en = 0; i_ex_dest_reg = 0; i_ex_is_load = 0;
        i_me_dest_en = 0; i_me_dest_reg = 0;
        i_ex_redirect = 0; i_ex_multi_start = 0;
    endtask

    task automatic expect_cycle(input string nm, input logic [4:0] st, input logic [4:0] cl,
                                input logic [1:0] fa, input logic [1:0] fb, input int fl);
        exp_t x;
        x.nm = nm; x.st = st; x.cl = cl; x.fa = fa; x.fb = fb; x.fl = fl;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic load_use_x5();
        i_ex_dest_en = 1; i_ex_dest_reg = 5'd5; i_ex_is_load = 1;
        i_id_rs1 = 5'd5; i_id_rs1_en = 1;
    endtask

    initial begin
        idle_inputs();
        aresetn = 0;
        @(posedge clk);
        #1;
        expect_cycle("reset", 5'b00000, 5'b11111, 2'b00, 2'b00, 0);

        // INIT ignores all inputs
        aresetn = 1;
        i_ex_redirect = 1; i_me_busy = 1; i_fe_busy = 1;
        load_use_x5();
        expect_cycle("init0", 5'b00000, 5'b11111, 2'b00, 2'b00, 0);
        idle_inputs();
        expect_cycle("init1", 5'b00000, 5'b11111, 2'b00, 2'b00, 0);
        expect_cycle("run_idle", 5'b00000, 5'b00000, 2'b00, 2'b00, 0);

        load_use_x5();
        expect_cycle("load_use", 5'b00011, 5'b00100, 2'b00, 2'b00, 0);
        i_ex_dest_en = 0; i_ex_is_load = 0; i_me_dest_en = 1; i_me_dest_reg = 5'd5;
        expect_cycle("load_in_me", FWD ? 5'b00000 : 5'b00011, FWD ? 5'b00000 : 5'b00100,
                     FWD ? 2'b10 : 2'b00, 2'b00, 0);

        idle_inputs();
        i_ex_dest_en = 1; i_ex_dest_reg = 5'd0; i_ex_is_load = 1;
        i_id_rs1_en = 1; i_id_rs2_en = 1;
        expect_cycle("x0_load", 5'b00000, 5'b00000, 2'b00, 2'b00, 0);

        idle_inputs();
        i_ex_dest_en = 1; i_ex_dest_reg = 5'd7; i_me_dest_en = 1; i_me_dest_reg = 5'd0;
        i_id_rs1 = 5'd0; i_id_rs1_en = 1; i_id_rs2 = 5'd7; i_id_rs2_en = 1;
        expect_cycle("x7_in_ex", FWD ? 5'b00000 : 5'b00011, FWD ? 5'b00000 : 5'b00100,
                     2'b00, FWD ? 2'b01 : 2'b00, 0);
        i_ex_dest_en = 0; i_me_dest_reg = 5'd7;
        expect_cycle("x7_in_me", FWD ? 5'b00000 : 5'b00011, FWD ? 5'b00000 : 5'b00100,
                     2'b00, FWD ? 2'b10 : 2'b00, 0);
        i_me_dest_en = 0;
        expect_cycle("x7_in_wb", 5'b00000, 5'b00000, 2'b00, 2'b00, 0);

        idle_inputs();
        i_ex_dest_en = 1; i_ex_dest_reg = 5'd9; i_me_dest_en = 1; i_me_dest_reg = 5'd9;
        i_id_rs1 = 5'd9; i_id_rs1_en = 1;
        expect_cycle("ex_over_me", FWD ? 5'b00000 : 5'b00011, FWD ? 5'b00000 : 5'b00100,
                     FWD ? 2'b01 : 2'b00, 2'b00, 0);

        idle_inputs();
        i_fe_busy = 1;
        expect_cycle("fe_busy", 5'b00001, 5'b00010, 2'b00, 2'b00, 0);
        load_use_x5();
        expect_cycle("lu_over_fe", 5'b00011, 5'b00100, 2'b00, 2'b00, 0);
        i_ex_redirect = 1;
        expect_cycle("redir_over_lu", 5'b00000, 5'b00110, 2'b00, 2'b00, 0);
        idle_inputs();
        expect_cycle("cnt_after_redir", 5'b00000, 5'b00000, 2'b00, 2'b00, 1);

        for (int i = 1; i <= 4; i++) begin
            i_ex_redirect = 1;
            expect_cycle("redir_burst", 5'b00000, 5'b00110, 2'b00, 2'b00, i);
        end
        idle_inputs();
        expect_cycle("cnt_saturate", 5'b00000, 5'b00000, 2'b00, 2'b00, 5);

        i_me_busy = 1; i_ex_redirect = 1;
        expect_cycle("me_busy_redir", 5'b01111, 5'b10000, 2'b00, 2'b00, 5);
        i_me_busy = 0;
        expect_cycle("redir_held", 5'b00000, 5'b00110, 2'b00, 2'b00, 5);
        idle_inputs();
        expect_cycle("cnt_6", 5'b00000, 5'b00000, 2'b00, 2'b00, 6);

        i_ex_multi_start = 1;
        expect_cycle("multi_start", 5'b00111, 5'b01000, 2'b00, 2'b00, 6);
        i_ex_multi_start = 0;
        for (int i = 0; i < 3; i++)
            expect_cycle("multi_hold", 5'b00111, 5'b01000, 2'b00, 2'b00, 6);
        expect_cycle("multi_done", 5'b00000, 5'b00000, 2'b00, 2'b00, 6);

        i_ex_multi_start = 1;
        expect_cycle("multi2_start", 5'b00111, 5'b01000, 2'b00, 2'b00, 6);
        i_ex_multi_start = 0;
        expect_cycle("multi2_hold", 5'b00111, 5'b01000, 2'b00, 2'b00, 6);
        i_me_busy = 1; i_ex_redirect = 1;
        expect_cycle("multi2_mebusy", 5'b01111, 5'b10000, 2'b00, 2'b00, 6);
        expect_cycle("multi2_mebusy", 5'b01111, 5'b10000, 2'b00, 2'b00, 6);
        idle_inputs();
        expect_cycle("multi2_resume", 5'b00111, 5'b01000, 2'b00, 2'b00, 6);
        expect_cycle("multi2_last", 5'b00111, 5'b01000, 2'b00, 2'b00, 6);
        expect_cycle("multi2_done", 5'b00000, 5'b00000, 2'b00, 2'b00, 6);

        i_ex_multi_start = 1;
        expect_cycle("multi3_start", 5'b00111, 5'b01000, 2'b00, 2'b00, 6);
        i_ex_multi_start = 0;
        expect_cycle("multi3_hold", 5'b00111, 5'b01000, 2'b00, 2'b00, 6);
        aresetn = 0;
        expect_cycle("async_reset", 5'b00000, 5'b11111, 2'b00, 2'b00, 0);
        aresetn = 1;
        expect_cycle("reinit0", 5'b00000, 5'b11111, 2'b00, 2'b00, 0);
        expect_cycle("reinit1", 5'b00000, 5'b11111, 2'b00, 2'b00, 0);
        expect_cycle("rerun_idle", 5'b00000, 5'b00000, 2'b00, 2'b00, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        #2;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
